uart_tx_arbiter: RTL and testbench
==================================

Name: uart_tx_arbiter

Overview:
Round-robin scheduler that shares one UART transmitter among N_REQ requesters. Each requester presents one byte plus a 4-bit line-control word through a valid/ready handshake. The arbiter latches the winning request, drives the transmitter's baud_sel, line_control_reg and data_input, and holds them until the frame completes. It then enforces an inter-frame gap and rotates priority. It sits between the host-side request ports and the transmitter top module, in the 18.432 MHz clock domain.

Parameters:
N_REQ, 4, number of requesters (2..8).
GAP_CYCLES, 16, idle clocks between frames (0 allowed; 10-bit counter).
TIMEOUT_CYCLES, 2000000, watchdog limit in clocks; used only with the optional feature.

Ports:
clk  in  1  system clock, 18.432 MHz
rst  in  1  asynchronous active-low reset; the block is in reset while rst=0
req_valid  in  N_REQ  per-requester frame request
req_data  in  8*N_REQ  byte for requester i at [8i+7:8i]
req_lcr  in  4*N_REQ  line control for requester i at [4i+3:4i] (data length/stop/parity)
req_ready  out  N_REQ  one-hot, one-cycle accept pulse
cfg_baud  in  2  requested baud select
tx_baud_sel  out  2  to transmitter baud_sel
tx_lcr  out  5  to transmitter line_control_reg; bit4 is the hold bit (1 = transmitter idle)
tx_data  out  8  to transmitter data_input
tx_active  in  1  transmitter active_flag
tx_done  in  1  transmitter done_flag
grant_id  out  3  index of the current or last granted requester
busy  out  1  high in every state except IDLE
err  out  1  sticky watchdog error (only with the optional feature; tied 0 otherwise)

Behaviour:
- Reset values (async, rst=0): tx_lcr=5'b10000, tx_data=0, tx_baud_sel=0, req_ready=0, grant_id=0, busy=0, err=0, rr_ptr=0, gap counter=0, state=IDLE.
- States: IDLE, LAUNCH, WAIT_ACT, WAIT_DONE, GAP.
- IDLE:
  - tx_baud_sel<=cfg_baud every cycle. Baud changes only take effect here, never mid-frame.
  - If any req_valid is set, pick the first set bit scanning from rr_ptr upward, wrapping modulo N_REQ.
  - Same cycle: pulse req_ready[i], capture req_data[i] and req_lcr[i], set grant_id<=i, go to LAUNCH.
- LAUNCH (1 cycle): tx_data<=captured byte, tx_lcr<={1'b0, captured lcr}. Go to WAIT_ACT.
  - Latency from the accept cycle to tx_lcr[4]=0 is 1 clock.
- WAIT_ACT: wait for tx_active=1, then go to WAIT_DONE. A tx_done seen in this state is ignored as stale.
- WAIT_DONE: on a tx_done rising edge (registered previous value):
  - tx_lcr[4]<=1; tx_data holds its value.
  - rr_ptr<=(grant_id+1) mod N_REQ.
  - Load the gap counter with GAP_CYCLES and go to GAP.
- GAP: decrement to 0, then go to IDLE. If GAP_CYCLES=0, go straight to IDLE the next cycle.
- tx_data and tx_lcr[3:0] are stable from LAUNCH until the next LAUNCH.
- Handshake rule: requesters hold req_valid and data stable until req_ready. Deassertion before grant is legal, and such a requester is simply skipped.
- Exactly one accept per frame. A requester holding req_valid continuously is served at most once per full rotation while others are pending. A single lone requester is served back-to-back, separated by GAP_CYCLES.
- Reset asserted mid-frame: outputs return to reset values immediately, including tx_lcr[4]=1. Any in-flight frame is abandoned and not retried.
- cfg_baud changes while busy: latched on the first IDLE cycle.

Optional Feature:
UART_ARB_TIMEOUT_EN:
- Defined: a 21-bit watchdog counts clocks in WAIT_ACT and WAIT_DONE. On reaching TIMEOUT_CYCLES it sets tx_lcr[4]=1, sets err=1 (sticky until reset), advances rr_ptr and goes to GAP.
- Undefined: no counter; the arbiter waits indefinitely, err is tied 0, and TIMEOUT_CYCLES is ignored.

Test Plan:
- Reset: rst=0 with random inputs -> tx_lcr=5'b10000, req_ready=0, busy=0. Release rst; with no requests, busy stays 0 for 100 clocks.
- Single request: req_valid=4'b0010, req_data[15:8]=8'hAA, req_lcr[7:4]=4'b0011.
  - Expect req_ready=4'b0010 for 1 cycle, grant_id=1.
  - Next clock: tx_lcr=5'b00011, tx_data=8'hAA.
  - After tx_done: tx_lcr[4]=1, then GAP_CYCLES idle clocks.
- Round-robin: all four requesters valid continuously -> grant order 0,1,2,3,0 with no repeats within a rotation.
- Baud change: set cfg_baud=2'b10 during a frame -> tx_baud_sel unchanged until IDLE, then 2'b10 before the next LAUNCH.
- Mid-frame reset: assert rst=0 while in WAIT_DONE -> tx_lcr=5'b10000 in the same timestep. After release, the arbiter restarts from requester 0.
- With UART_ARB_TIMEOUT_EN and TIMEOUT_CYCLES=50: grant a request, never assert tx_active -> after 50 clocks tx_lcr[4]=1, err=1, and the next requester is granted.

Source files
------------

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin scheduler sharing one UART transmitter among
// N_REQ requesters. Latches the winning byte/line-control word, holds the
// transmitter outputs for the whole frame, then inserts an inter-frame gap.
// Optional watchdog: define UART_ARB_TIMEOUT_EN to abort frames that never
// start or never finish within TIMEOUT_CYCLES clocks (sets sticky err).
module uart_tx_arbiter #(
   parameter int N_REQ          = 4,
   parameter int GAP_CYCLES     = 16,
   parameter int TIMEOUT_CYCLES = 2000000
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [N_REQ-1:0]     req_valid,
   input  logic [8*N_REQ-1:0]   req_data,
   input  logic [4*N_REQ-1:0]   req_lcr,
   output logic [N_REQ-1:0]     req_ready,
   input  logic [1:0]           cfg_baud,
   output logic [1:0]           tx_baud_sel,
   output logic [4:0]           tx_lcr,
   output logic [7:0]           tx_data,
   input  logic                 tx_active,
   input  logic                 tx_done,
   output logic [2:0]           grant_id,
   output logic                 busy,
   output logic                 err
);

   typedef enum logic [2:0] {
      S_IDLE, S_LAUNCH, S_WAIT_ACT, S_WAIT_DONE, S_GAP
   } state_e;

   localparam logic [9:0] GAP_LD  = 10'(GAP_CYCLES);
   localparam logic [2:0] LAST_ID = 3'(N_REQ - 1);

   state_e             state_q, state_d;
   logic [2:0]         rr_ptr_q, rr_ptr_d;
   logic [9:0]         gap_q, gap_d;
   logic [7:0]         cap_data_q, cap_data_d;
   logic [3:0]         cap_lcr_q, cap_lcr_d;
   logic [N_REQ-1:0]   req_ready_q, req_ready_d;
   logic [2:0]         grant_q, grant_d;
   logic [1:0]         baud_q, baud_d;
   logic [4:0]         tx_lcr_q, tx_lcr_d;
   logic [7:0]         tx_data_q, tx_data_d;
   logic               done_q;
   logic               finish;

   // Zero-padded per-requester views so an 8-entry index never goes out of range
   logic [7:0]         valid_pad;
   logic [63:0]        data_pad;
   logic [31:0]        lcr_pad;
   logic [7:0]         data_arr [8];
   logic [3:0]         lcr_arr  [8];
   logic               pick_found;
   logic [2:0]         pick_idx;
   logic [3:0]         scan;

   // Round-robin pick: first valid requester scanning upward from rr_ptr, wrapping
   always_comb begin
      valid_pad  = 8'(req_valid);
      data_pad   = 64'(req_data);
      lcr_pad    = 32'(req_lcr);
      pick_found = 1'b0;
      pick_idx   = '0;
      scan       = '0;
      for (int k = 0; k < 8; k++) begin
         data_arr[k] = data_pad[k*8 +: 8];
         lcr_arr[k]  = lcr_pad[k*4 +: 4];
         scan = {1'b0, rr_ptr_q} + 4'(k);
         if (scan >= 4'(N_REQ)) scan = scan - 4'(N_REQ);
         if (k < N_REQ && !pick_found && valid_pad[scan[2:0]]) begin
            pick_found = 1'b1;
            pick_idx   = scan[2:0];
         end
      end
   end

`ifdef UART_ARB_TIMEOUT_EN
   localparam logic [20:0] WDOG_LIM = 21'(TIMEOUT_CYCLES - 1);
   logic [20:0] wdog_q, wdog_d;
   logic        err_q, err_d;
`endif

   // Next-state and next-output logic for the frame scheduler
   always_comb begin
      // NOTE: every _d gets a default first so no path leaves a latch behind.
      state_d     = state_q;
      rr_ptr_d    = rr_ptr_q;
      gap_d       = gap_q;
      cap_data_d  = cap_data_q;
      cap_lcr_d   = cap_lcr_q;
      req_ready_d = '0;
      grant_d     = grant_q;
      baud_d      = baud_q;
      tx_lcr_d    = tx_lcr_q;
      tx_data_d   = tx_data_q;
      finish      = 1'b0;
`ifdef UART_ARB_TIMEOUT_EN
      wdog_d      = '0;
      err_d       = err_q;
`endif
      case (state_q)
         S_IDLE: begin
            baud_d = cfg_baud;
            if (pick_found) begin
               req_ready_d = N_REQ'(1) << pick_idx;
               cap_data_d  = data_arr[pick_idx];
               cap_lcr_d   = lcr_arr[pick_idx];
               grant_d     = pick_idx;
               state_d     = S_LAUNCH;
            end
         end
         S_LAUNCH: begin
            tx_data_d = cap_data_q;
            tx_lcr_d  = {1'b0, cap_lcr_q};
            state_d   = S_WAIT_ACT;
         end
         S_WAIT_ACT: begin
            // A done pulse here belongs to an earlier frame and is ignored
            if (tx_active) state_d = S_WAIT_DONE;
         end
         S_WAIT_DONE: begin
            if (tx_done && !done_q) finish = 1'b1;
         end
         S_GAP: begin
            if (gap_q > 10'd1) begin
               gap_d = gap_q - 10'd1;
            end else begin
               gap_d   = '0;
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
`ifdef UART_ARB_TIMEOUT_EN
      if (state_q == S_WAIT_ACT || state_q == S_WAIT_DONE) begin
         wdog_d = wdog_q + 21'd1;
         if (wdog_q == WDOG_LIM) begin
            finish = 1'b1;
            err_d  = 1'b1;
         end
      end
`endif
      if (finish) begin
         tx_lcr_d[4] = 1'b1;
         rr_ptr_d    = (grant_q == LAST_ID) ? 3'd0 : grant_q + 3'd1;
         gap_d       = GAP_LD;
         state_d     = S_GAP;
      end
   end

   // State and output registers; reset drops the transmitter back to hold
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= S_IDLE;
         rr_ptr_q    <= '0;
         gap_q       <= '0;
         cap_data_q  <= '0;
         cap_lcr_q   <= '0;
         req_ready_q <= '0;
         grant_q     <= '0;
         baud_q      <= '0;
         tx_lcr_q    <= 5'b10000;
         tx_data_q   <= '0;
         done_q      <= 1'b0;
      end else begin
         // NOTE: non-blocking so every register samples pre-edge values.
         state_q     <= state_d;
         rr_ptr_q    <= rr_ptr_d;
         gap_q       <= gap_d;
         cap_data_q  <= cap_data_d;
         cap_lcr_q   <= cap_lcr_d;
         req_ready_q <= req_ready_d;
         grant_q     <= grant_d;
         baud_q      <= baud_d;
         tx_lcr_q    <= tx_lcr_d;
         tx_data_q   <= tx_data_d;
         done_q      <= tx_done;
      end
   end

`ifdef UART_ARB_TIMEOUT_EN
   // Watchdog counter and sticky error flag
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wdog_q <= '0;
         err_q  <= 1'b0;
      end else begin
         wdog_q <= wdog_d;
         err_q  <= err_d;
      end
   end
   assign err = err_q;
`else
   assign err = 1'b0;
`endif

   assign req_ready   = req_ready_q;
   assign tx_baud_sel = baud_q;
   assign tx_lcr      = tx_lcr_q;
   assign tx_data     = tx_data_q;
   assign grant_id    = grant_q;
   assign busy        = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: reset, single frame timing, stale done,
// gap length, baud latching, mid-frame reset, round-robin order, lone
// requester, and (with UART_ARB_TIMEOUT_EN) the watchdog abort.
module tb_uart_tx_arbiter;

   localparam int N   = 4;
   localparam int GAP = 16;
`ifdef UART_ARB_TIMEOUT_EN
   localparam int TO  = 50;
`else
   localparam int TO  = 2000000;
`endif

   logic          clk = 1'b0;
   logic          rst;
   logic [N-1:0]  req_valid;
   logic [8*N-1:0] req_data;
   logic [4*N-1:0] req_lcr;
   logic [N-1:0]  req_ready;
   logic [1:0]    cfg_baud;
   logic [1:0]    tx_baud_sel;
   logic [4:0]    tx_lcr;
   logic [7:0]    tx_data;
   logic          tx_active;
   logic          tx_done;
   logic [2:0]    grant_id;
   logic          busy;
   logic          err;

   int n_checks = 0;
   int n_errors = 0;

   uart_tx_arbiter #(.N_REQ(N), .GAP_CYCLES(GAP), .TIMEOUT_CYCLES(TO)) dut (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
      .req_lcr(req_lcr), .req_ready(req_ready), .cfg_baud(cfg_baud),
      .tx_baud_sel(tx_baud_sel), .tx_lcr(tx_lcr), .tx_data(tx_data),
      .tx_active(tx_active), .tx_done(tx_done), .grant_id(grant_id),
      .busy(busy), .err(err)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Advance one clock and sample at the following falling edge
   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic wait_accept(input string tag);
      int t = 0;
      while (req_ready == '0 && t < 50) begin
         step();
         t++;
      end
      check({tag, "_accept"}, 32'(req_ready != '0), 1);
   endtask

   task automatic wait_idle(input string tag);
      int t = 0;
      while (busy && t < 100) begin
         step();
         t++;
      end
      check({tag, "_idle"}, 32'(busy), 0);
   endtask

   // Called at the LAUNCH sample point; runs the transmitter side of a frame
   task automatic finish_frame(input string tag, input logic [7:0] exp_data);
      step();
      check({tag, "_data"}, 32'(tx_data), 32'(exp_data));
      check({tag, "_go"}, 32'(tx_lcr[4]), 0);
      tx_active = 1'b1;
      step();
      tx_done = 1'b1;
      step();
      check({tag, "_hold"}, 32'(tx_lcr[4]), 1);
      tx_done   = 1'b0;
      tx_active = 1'b0;
      wait_idle(tag);
   endtask

   initial begin
      int cnt;
      logic [2:0] exp_id;

      // Reset with random inputs
      rst       = 1'b0;
      req_valid = 4'($urandom);
      req_data  = $urandom;
      req_lcr   = 16'($urandom);
      cfg_baud  = 2'($urandom);
      tx_active = 1'($urandom);
      tx_done   = 1'($urandom);
      #12;
      check("rst_lcr", 32'(tx_lcr), 32'h10);
      check("rst_ready", 32'(req_ready), 0);
      check("rst_busy", 32'(busy), 0);
      check("rst_grant", 32'(grant_id), 0);
      check("rst_data", 32'(tx_data), 0);
      check("rst_err", 32'(err), 0);
      req_valid = '0;
      tx_active = 1'b0;
      tx_done   = 1'b0;
      cfg_baud  = 2'b00;
      @(negedge clk);
      rst = 1'b1;
      cnt = 0;
      for (int i = 0; i < 100; i++) begin
         step();
         if (busy) cnt++;
      end
      check("idle_no_req_busy", cnt, 0);

      // Single request from requester 1
      req_data  = 32'h33_22_AA_11;
      req_lcr   = 16'h0030;
      req_valid = 4'b0010;
      step();
      check("single_ready", 32'(req_ready), 32'b0010);
      check("single_grant", 32'(grant_id), 1);
      step();
      check("single_ready_pulse", 32'(req_ready), 0);
      check("single_lcr", 32'(tx_lcr), 32'b00011);
      check("single_data", 32'(tx_data), 32'hAA);
      req_valid = '0;
      tx_done   = 1'b1;                  // stale done while waiting for active
      step();
      check("stale_done_ignored", 32'(tx_lcr), 32'b00011);
      tx_done   = 1'b0;
      tx_active = 1'b1;
      step();
      tx_done = 1'b1;
      step();
      check("done_lcr", 32'(tx_lcr), 32'b10011);
      check("done_data_held", 32'(tx_data), 32'hAA);
      tx_done   = 1'b0;
      tx_active = 1'b0;
      cnt = 0;
      while (busy && cnt < 100) begin
         cnt++;
         step();
      end
      check("gap_length", cnt, GAP);

      // Baud change mid-frame takes effect only back in IDLE
      cfg_baud = 2'b01;
      step();
      check("baud_idle", 32'(tx_baud_sel), 32'b01);
      req_data  = 32'h00_55_00_00;
      req_lcr   = 16'h0500;
      req_valid = 4'b0100;
      step();
      check("baud_grant", 32'(grant_id), 2);
      cfg_baud = 2'b10;
      step();
      req_valid = '0;
      check("baud_lcr", 32'(tx_lcr), 32'b00101);
      tx_active = 1'b1;
      step();
      check("baud_mid_frame", 32'(tx_baud_sel), 32'b01);
      tx_done = 1'b1;
      step();
      tx_done   = 1'b0;
      tx_active = 1'b0;
      wait_idle("baud");
      step();
      check("baud_after_idle", 32'(tx_baud_sel), 32'b10);
      check("baud_lcr_stable", 32'(tx_lcr), 32'b10101);
      check("baud_data_stable", 32'(tx_data), 32'h55);

      // Reset asserted while waiting for done
      req_data  = 32'hC3_00_00_00;
      req_lcr   = 16'h9000;
      req_valid = 4'b1000;
      step();
      check("mrst_grant", 32'(grant_id), 3);
      step();
      req_valid = '0;
      tx_active = 1'b1;
      step();
      check("mrst_busy", 32'(busy), 1);
      check("mrst_lcr_pre", 32'(tx_lcr), 32'b01001);
      #2 rst = 1'b0;
      #1;
      check("mrst_lcr", 32'(tx_lcr), 32'h10);
      check("mrst_data", 32'(tx_data), 0);
      check("mrst_busy_low", 32'(busy), 0);
      check("mrst_grant_zero", 32'(grant_id), 0);
      check("mrst_baud", 32'(tx_baud_sel), 0);
      tx_active = 1'b0;
      cfg_baud  = 2'b00;
      @(negedge clk);
      rst = 1'b1;

      // All four requesting continuously: 0,1,2,3,0
      req_data  = 32'hD3_D2_D1_D0;
      req_lcr   = 16'h4321;
      req_valid = 4'b1111;
      for (int f = 0; f < 5; f++) begin
         exp_id = 3'(f % 4);
         wait_accept("rr");
         check("rr_grant", 32'(grant_id), 32'(exp_id));
         check("rr_ready", 32'(req_ready), 32'(4'b0001 << exp_id));
         finish_frame("rr", 8'hD0 + 8'(exp_id));
      end
      req_valid = '0;

      // Lone requester served back to back
      req_valid = 4'b0001;
      for (int f = 0; f < 2; f++) begin
         wait_accept("lone");
         check("lone_grant", 32'(grant_id), 0);
         finish_frame("lone", 8'hD0);
      end
      req_valid = '0;
      check("err_clear", 32'(err), 0);

`ifdef UART_ARB_TIMEOUT_EN
      // Transmitter never goes active: watchdog aborts and rotates
      req_valid = 4'b0110;
      wait_accept("wdog");
      check("wdog_grant", 32'(grant_id), 1);
      step();
      cnt = 0;
      while (tx_lcr[4] == 1'b0 && cnt < 200) begin
         cnt++;
         step();
      end
      check("wdog_cycles", cnt, TO);
      check("wdog_err", 32'(err), 1);
      wait_idle("wdog");
      wait_accept("wdog_next");
      check("wdog_next_grant", 32'(grant_id), 2);
      finish_frame("wdog_next", 8'hD2);
      check("wdog_err_sticky", 32'(err), 1);
      req_valid = '0;
`endif

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

   // Global bound so the bench cannot hang
   initial begin
      #2000000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1, "simulation time limit");
   end

endmodule
